// File: rtl/dec_history_buf.sv
// History buffer of previously decoded instruction blocks, newest at index 0, with parallel PC lookup.
// Optional most-recently-used promotion on channel-0 hits: define RIVER_DEC_HIST_MRU_EN.
module dec_history_buf #(
   parameter int unsigned abits = 64,
   parameter int unsigned dbits = 128,
   parameter int unsigned depth = 8,
   parameter int unsigned chans = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_wr_valid,
   input  logic [abits-1:0]           i_wr_pc,
   input  logic [dbits-1:0]           i_wr_data,
   input  logic [chans-1:0]           i_req_valid,
   input  logic [chans*abits-1:0]     i_req_pc,
   output logic [chans-1:0]           o_resp_valid,
   output logic [chans-1:0]           o_resp_hit,
   output logic [chans*dbits-1:0]     o_resp_data,
   output logic [$clog2(depth+1)-1:0] o_count
);

   localparam int unsigned iw = $clog2(depth);
   localparam int unsigned cw = $clog2(depth + 1);

   logic [abits-1:0] pc_q   [depth];
   logic [dbits-1:0] data_q [depth];
   logic [depth-1:0] vld_q;

   logic [abits-1:0] pc_d   [depth];
   logic [dbits-1:0] data_d [depth];
   logic [depth-1:0] vld_d;
   logic [cw-1:0]    cnt_d;

   logic [chans-1:0] lk_hit;
   logic [iw-1:0]    lk_idx  [chans];
   logic [dbits-1:0] lk_data [chans];
   logic [chans*dbits-1:0] resp_data_d;

   logic             wr_hit;
   logic [iw-1:0]    wr_idx;

   // Parallel lookup against pre-edge contents; lowest matching index wins.
   always_comb begin
      resp_data_d = '0;
      for (int k = 0; k < int'(chans); k++) begin
         lk_hit[k] = 1'b0;
         lk_idx[k] = '0;
         for (int i = int'(depth) - 1; i >= 0; i--) begin
            if (vld_q[i] && (pc_q[i] == i_req_pc[k*abits +: abits])) begin
               lk_hit[k] = 1'b1;
               lk_idx[k] = iw'(i);
            end
         end
         lk_data[k] = lk_hit[k] ? data_q[lk_idx[k]] : '0;
         if (i_req_valid[k]) resp_data_d[k*dbits +: dbits] = lk_data[k];
      end
   end

   // Duplicate detection for the insert port.
   always_comb begin
      wr_hit = 1'b0;
      wr_idx = '0;
      for (int i = int'(depth) - 1; i >= 0; i--) begin
         if (vld_q[i] && (pc_q[i] == i_wr_pc)) begin
            wr_hit = 1'b1;
            wr_idx = iw'(i);
         end
      end
   end

   // Next-state of the storage: flush beats insert beats promotion.
   always_comb begin
      pc_d   = pc_q;
      data_d = data_q;
      vld_d  = vld_q;
      if (i_flush) begin
         vld_d = '0;
      end else if (i_wr_valid) begin
         if (wr_hit) begin
            data_d[wr_idx] = i_wr_data;
         end else begin
            for (int i = 1; i < int'(depth); i++) begin
               pc_d[i]   = pc_q[i-1];
               data_d[i] = data_q[i-1];
               vld_d[i]  = vld_q[i-1];
            end
            pc_d[0]   = i_wr_pc;
            data_d[0] = i_wr_data;
            vld_d[0]  = 1'b1;
         end
      end
`ifdef RIVER_DEC_HIST_MRU_EN
      else if (i_req_valid[0] && lk_hit[0] && (lk_idx[0] != '0)) begin
         for (int i = 1; i < int'(depth); i++) begin
            if (iw'(i) <= lk_idx[0]) begin
               pc_d[i]   = pc_q[i-1];
               data_d[i] = data_q[i-1];
               vld_d[i]  = vld_q[i-1];
            end
         end
         pc_d[0]   = pc_q[lk_idx[0]];
         data_d[0] = data_q[lk_idx[0]];
         vld_d[0]  = 1'b1;
      end
`endif
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < int'(depth); i++) cnt_d = cnt_d + cw'(vld_d[i]);
   end

   // PC and payload contents are meaningless without vld, so they carry no reset.
   always_ff @(posedge i_clk) begin
      pc_q   <= pc_d;
      data_q <= data_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_q        <= '0;
         o_count      <= '0;
         o_resp_valid <= '0;
         o_resp_hit   <= '0;
         o_resp_data  <= '0;
      end else begin
         vld_q        <= vld_d;
         o_count      <= cnt_d;
         o_resp_valid <= i_req_valid;
         o_resp_hit   <= i_req_valid & lk_hit;
         o_resp_data  <= resp_data_d;
      end
   end

endmodule
